// File: rtl/piso_bitstream_src.sv
// Parallel-in/serial-out bitstream source: accepts W-bit words on a valid/ready
// handshake and shifts them out one bit per bit_en cycle on a registered dout.
module piso_bitstream_src #(
  parameter int   W         = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_done
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bit_idx;
  logic          last_bit;
  logic          accept;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. A word pending on the last bit keeps us in SHIFT.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/handshake logic: ready on IDLE or on the edge that emits the last bit.
  always_comb begin
    last_bit = (state == SHIFT) && (cnt == LAST) && bit_en;
    in_ready = (state == IDLE) || last_bit;
    accept   = in_valid && in_ready;
    bit_idx  = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;
  end

  assign busy = (state == SHIFT);

  // Datapath: shift register, bit counter, serial output and word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      cnt        <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      words_done <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (state == IDLE) begin
        dout <= IDLE_BIT;
      end else if (bit_en) begin
        dout       <= shreg[bit_idx];
        dout_valid <= 1'b1;
        if (cnt != LAST) cnt        <= cnt + 1'b1;
        else             words_done <= words_done + 1'b1;
      end
      // A load on the last-bit edge overrides the counter advance above.
      if (accept) begin
        shreg <= in_data;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_piso_bitstream_src.sv
// Self-checking bench for piso_bitstream_src: three instances (MSB-first, LSB-first,
// 2-bit counter) share stimulus and are compared against a word/bit queue model.
module tb_piso_bitstream_src;

  localparam int   W        = 8;
  localparam logic IDLE_BIT = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_en;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic         in_ready, dout, dout_valid, busy;
  logic [15:0]  words_done;
  logic         in_ready_l, dout_l, dout_valid_l, busy_l;
  logic [15:0]  words_done_l;
  logic         in_ready_2, dout_2, dout_valid_2, busy_2;
  logic [1:0]   words_done_2;

  int errors = 0;
  int checks = 0;

  piso_bitstream_src #(.W(W), .MSB_FIRST(1), .IDLE_BIT(IDLE_BIT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .words_done(words_done)
  );

  piso_bitstream_src #(.W(W), .MSB_FIRST(0), .IDLE_BIT(IDLE_BIT), .CNT_W(16)) dut_lsb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .dout(dout_l), .dout_valid(dout_valid_l), .busy(busy_l),
    .words_done(words_done_l)
  );

  piso_bitstream_src #(.W(W), .MSB_FIRST(1), .IDLE_BIT(IDLE_BIT), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_2), .dout(dout_2), .dout_valid(dout_valid_2), .busy(busy_2),
    .words_done(words_done_2)
  );

  always #5 clk = ~clk;

  // Reference model: current word and how many of its bits remain to be sent.
  logic [W-1:0] m_word;
  int           m_left;
  int           m_done;
  logic         m_dout, m_dout_l, m_dv;

  logic [W-1:0] tx_q[$];
  logic         obs_q[$];
  logic         obs_l_q[$];
  logic [1:0]   wd2_hist[$];
  int           first_dv, last_dv;

  task automatic model_reset();
    m_left   = 0;
    m_done   = 0;
    m_dout   = IDLE_BIT;
    m_dout_l = IDLE_BIT;
    m_dv     = 1'b0;
  endtask

  function automatic logic [15:0] pack_obs(input bit lsb_inst);
    logic [15:0] v = '0;
    if (lsb_inst) foreach (obs_l_q[i]) v = {v[14:0], obs_l_q[i]};
    else          foreach (obs_q[i])   v = {v[14:0], obs_q[i]};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    in_valid = 1'b0;
    bit_en   = 1'b0;
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  // Drives tx_q through the handshake. period: 1 = bit_en always, N = every Nth cycle,
  // 0 = random. valid_pct: chance per cycle that a waiting word gets offered.
  task automatic run(input int period, input int valid_pct, input int abort_bits,
                     input int max_cycles);
    int   cyc = 0;
    int   tail = 0;
    int   pos;
    int   prev_done;
    bit   offered = 1'b0;
    logic en, exp_ready, acc, exp_busy;
    obs_q.delete();
    obs_l_q.delete();
    wd2_hist.delete();
    first_dv  = -1;
    last_dv   = -1;
    prev_done = m_done;
    while (tail < 2 && cyc < max_cycles) begin
      if (!offered && tx_q.size() > 0) offered = ($urandom_range(99) < valid_pct);
      in_valid = offered;
      in_data  = offered ? tx_q[0] : W'($urandom);
      if (period == 0)      en = 1'($urandom_range(1));
      else if (period == 1) en = 1'b1;
      else                  en = ((cyc % period) == period - 1);
      bit_en    = en;
      exp_ready = (m_left == 0) || (m_left == 1 && en);
      #1;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
      end
      checks++;
      if ({in_ready_l, in_ready_2} !== {exp_ready, exp_ready}) begin
        errors++;
        $display("FAIL in_ready_aux cyc=%0d got=%b%b exp=%b", cyc, in_ready_l, in_ready_2, exp_ready);
      end
      acc = offered && exp_ready;
      @(posedge clk);
      m_dv = 1'b0;
      if (m_left == 0) begin
        m_dout   = IDLE_BIT;
        m_dout_l = IDLE_BIT;
      end else if (en) begin
        pos      = W - m_left;
        m_dout   = m_word[W-1-pos];
        m_dout_l = m_word[pos];
        m_dv     = 1'b1;
        m_left--;
        if (m_left == 0) m_done++;
      end
      if (acc) begin
        m_word  = tx_q.pop_front();
        m_left  = W;
        offered = 1'b0;
      end
      exp_busy = (m_left != 0);
      #1;
      checks++;
      if (dout !== m_dout) begin
        errors++;
        $display("FAIL dout cyc=%0d got=%b exp=%b", cyc, dout, m_dout);
      end
      checks++;
      if (dout_valid !== m_dv) begin
        errors++;
        $display("FAIL dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, m_dv);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      checks++;
      if (words_done !== 16'(m_done)) begin
        errors++;
        $display("FAIL words_done cyc=%0d got=%0d exp=%0d", cyc, words_done, m_done);
      end
      checks++;
      if ({dout_l, dout_valid_l} !== {m_dout_l, m_dv}) begin
        errors++;
        $display("FAIL lsb_dout cyc=%0d got=%b/%b exp=%b/%b", cyc, dout_l, dout_valid_l, m_dout_l, m_dv);
      end
      checks++;
      if (words_done_2 !== 2'(m_done)) begin
        errors++;
        $display("FAIL words_done_c2 cyc=%0d got=%0d exp=%0d", cyc, words_done_2, m_done % 4);
      end
      checks++;
      if ({busy_l, busy_2, dout_valid_2, dout_2, words_done_l} !==
          {exp_busy, exp_busy, m_dv, m_dout, 16'(m_done)}) begin
        errors++;
        $display("FAIL aux_outputs cyc=%0d busy_l=%b busy_2=%b dv_2=%b dout_2=%b wd_l=%0d exp busy=%b dv=%b dout=%b wd=%0d",
                 cyc, busy_l, busy_2, dout_valid_2, dout_2, words_done_l, exp_busy, m_dv, m_dout, m_done);
      end
      if (dout_valid) begin
        obs_q.push_back(dout);
        obs_l_q.push_back(dout_l);
        if (first_dv < 0) first_dv = cyc;
        last_dv = cyc;
      end
      if (m_done != prev_done) wd2_hist.push_back(words_done_2);
      prev_done = m_done;
      if (tx_q.size() == 0 && m_left == 0) tail++;
      cyc++;
      if (abort_bits > 0 && obs_q.size() >= abort_bits) break;
    end
    checks++;
    if (cyc >= max_cycles) begin
      errors++;
      $display("FAIL timeout cycles=%0d limit=%0d", cyc, max_cycles);
    end
    in_valid = 1'b0;
    bit_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    bit_en   = 1'b0;
    in_data  = '0;
    model_reset();
    #12;
    checks++;
    if ({dout, dout_valid, busy} !== {IDLE_BIT, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs got dout=%b dv=%b busy=%b", dout, dout_valid, busy);
    end
    checks++;
    if (words_done !== 16'd0 || words_done_2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d/%0d exp=0", words_done, words_done_2);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_single();
    int hits = 0;
    do_reset();
    tx_q = '{8'hB0};
    run(1, 100, 0, 100);
    checks++;
    if (obs_q.size() != 8 || pack_obs(0) !== 16'h00B0) begin
      errors++;
      $display("FAIL single_bits got n=%0d val=%h exp n=8 val=b0", obs_q.size(), pack_obs(0));
    end
    for (int i = 3; i < obs_q.size(); i++)
      if ({obs_q[i-3], obs_q[i-2], obs_q[i-1], obs_q[i]} == 4'b1011) hits++;
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL single_1011_hits got=%0d exp=1", hits);
    end
    checks++;
    if (words_done !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end got wd=%0d busy=%b exp wd=1 busy=0", words_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_q = '{8'hFF, 8'h00};
    run(1, 100, 0, 100);
    checks++;
    if (obs_q.size() != 16 || pack_obs(0) !== 16'hFF00) begin
      errors++;
      $display("FAIL b2b_bits got n=%0d val=%h exp n=16 val=ff00", obs_q.size(), pack_obs(0));
    end
    checks++;
    if (last_dv - first_dv + 1 != 16) begin
      errors++;
      $display("FAIL b2b_gapless got span=%0d exp=16", last_dv - first_dv + 1);
    end
    checks++;
    if (words_done !== 16'd2) begin
      errors++;
      $display("FAIL b2b_words_done got=%0d exp=2", words_done);
    end
  endtask

  task automatic test_throttle();
    do_reset();
    tx_q = '{8'hA5};
    run(3, 100, 0, 200);
    checks++;
    if (obs_q.size() != 8 || pack_obs(0) !== 16'h00A5) begin
      errors++;
      $display("FAIL throttle_bits got n=%0d val=%h exp n=8 val=a5", obs_q.size(), pack_obs(0));
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    tx_q = '{8'h0D};
    run(1, 100, 0, 100);
    checks++;
    if (obs_l_q.size() != 8 || pack_obs(1) !== 16'h00B0) begin
      errors++;
      $display("FAIL lsb_bits got n=%0d val=%h exp n=8 val=b0", obs_l_q.size(), pack_obs(1));
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    tx_q = '{8'hF0};
    run(1, 100, 3, 100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, busy, dout_l, busy_l} !== {IDLE_BIT, 2'b00, IDLE_BIT, 1'b0} ||
        words_done !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got dout=%b dv=%b busy=%b wd=%0d exp dout=%b dv=0 busy=0 wd=0",
               dout, dout_valid, busy, words_done, IDLE_BIT);
    end
    model_reset();
    tx_q.delete();
    @(negedge clk) reset = 1'b0;
    tx_q = '{8'h96};
    run(1, 100, 0, 100);
    checks++;
    if (obs_q.size() != 8 || pack_obs(0) !== 16'h0096 || words_done !== 16'd1) begin
      errors++;
      $display("FAIL after_reset got n=%0d val=%h wd=%0d exp n=8 val=96 wd=1",
               obs_q.size(), pack_obs(0), words_done);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(W'($urandom));
    run(1, 100, 0, 200);
    checks++;
    if (wd2_hist.size() != 5) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=5", wd2_hist.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wd2_hist[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL wrap_seq idx=%0d got=%0d exp=%0d", i, wd2_hist[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 40; i++) tx_q.push_back(W'($urandom));
    run(0, 30, 0, 4000);
    checks++;
    if (obs_q.size() != 320 || words_done !== 16'd40) begin
      errors++;
      $display("FAIL random_totals got bits=%0d wd=%0d exp bits=320 wd=40", obs_q.size(), words_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_throttle();
    test_lsb_first();
    test_reset_mid_word();
    test_cnt_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_bitstream_src.md
Name: piso_bitstream_src

Overview:
Parallel-in/serial-out bitstream source. Accepts W-bit words over a valid/ready handshake and emits them one bit per enabled cycle on a registered serial output. It sits directly upstream of the serial sequence detectors and drives their din input. It supports gapless back-to-back words, bit-rate throttling via bit_en, and selectable bit order.

Parameters:
W, 8, word width in bits; legal values are W >= 2.
MSB_FIRST, 1, 1 = emit bit W-1 first; 0 = emit bit 0 first.
IDLE_BIT, 0, value driven on dout when no word is being shifted.
CNT_W, 16, width of the words-completed counter.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
bit_en  in  1  bit-rate strobe; one serial bit advances per cycle with bit_en=1.
in_valid  in  1  upstream word valid.
in_data  in  W  upstream word; sampled only on an accept edge.
in_ready  out  1  block can accept a word this cycle (combinational).
dout  out  1  serial bit, registered; feeds detector din.
dout_valid  out  1  registered; high for exactly one cycle per emitted bit.
busy  out  1  registered; state==SHIFT.
words_done  out  CNT_W  count of fully emitted words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, shreg=0, bit counter cnt=0;
  - dout=IDLE_BIT, dout_valid=0, busy=0, words_done=0.
  - Reset mid-word discards the partial word. No further bits are emitted and the count does not increment.
- States: IDLE and SHIFT.
- in_ready = (state==IDLE) || (state==SHIFT && cnt==W-1 && bit_en).
- Accept edge: a rising edge with in_valid && in_ready. At that edge shreg<=in_data and cnt<=0.
- IDLE:
  - dout holds IDLE_BIT and dout_valid=0.
  - On an accept edge: load the word and go to SHIFT. The load edge does not emit a bit.
  - in_valid with in_ready=0 is not possible in IDLE. Upstream must hold in_valid/in_data stable until accepted.
- SHIFT, edge with bit_en=1:
  - dout <= current bit: shreg[W-1-cnt] if MSB_FIRST, else shreg[cnt].
  - dout_valid <= 1.
  - If cnt < W-1: cnt <= cnt+1.
  - If cnt == W-1 (last bit):
    - words_done increments;
    - if in_valid, the next word loads on this same edge (cnt<=0, stay in SHIFT);
    - otherwise go to IDLE.
- SHIFT, edge with bit_en=0: dout holds its last value, dout_valid<=0, cnt is unchanged and no word is accepted.
- Returning to IDLE: on the first IDLE cycle dout still holds the last emitted bit. dout returns to IDLE_BIT on the next edge.
- Latency and throughput:
  - The first bit of a word appears on dout at the first bit_en edge after its accept edge. Minimum is 1 cycle.
  - With bit_en tied high and in_valid continuously asserted, the output is gapless: dout_valid is high every cycle after the first load.
- busy is high from the edge after the accept until the edge after the last bit with no follow-on word.
- Simultaneous reset with in_valid/bit_en: reset wins.
- words_done wraps from 2^CNT_W-1 to 0 without a flag.
- in_data is registered on accept; later changes to in_data do not affect the word in flight.

Test Plan:
- Reset, then bit_en=1, MSB_FIRST=1, in_data=8'hB0 pulsed once:
  - accepted at the IDLE edge; dout_valid high for 8 cycles with dout 1,0,1,1,0,0,0,0;
  - busy falls afterwards, words_done=1;
  - the downstream detector flags one 1011 hit.
- Back-to-back 8'hFF then 8'h00 with in_valid held, bit_en=1:
  - in_ready pulses on the last bit of the first word;
  - 16 consecutive dout_valid cycles with no gap, dout 1x8 then 0x8; words_done=2.
- 8'hA5 with bit_en asserted every 3rd cycle:
  - exactly 8 dout_valid pulses, each aligned to a bit_en edge;
  - dout holds between pulses; bits 1,0,1,0,0,1,0,1.
- MSB_FIRST=0, in_data=8'h0D -> bits 1,0,1,1,0,0,0,0 (LSB first).
- Assert reset after the 3rd bit of 8'hF0:
  - dout=IDLE_BIT, dout_valid=0, busy=0, words_done=0 immediately (asynchronous);
  - the next word after release streams from its own first bit.
- CNT_W=2, 5 words streamed -> words_done sequence 1,2,3,0,1.
